// File: rtl/alu_issue_wb.sv
// Operand-fetch / write-back stage wrapped around a combinational ALU.
// One instruction at a time: IDLE accepts and reads operands, EXEC drives the
// ALU and captures its result, WB pulses wb_valid and commits to the regfile.
module alu_issue_wb #(
  parameter int unsigned data_width = 16,
  parameter int unsigned num_regs   = 4,
  localparam int unsigned AddrW     = (num_regs > 1) ? $clog2(num_regs) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_func,
  input  logic [AddrW-1:0]      in_rd,
  input  logic [AddrW-1:0]      in_rs1,
  input  logic [AddrW-1:0]      in_rs2,
  output logic [data_width-1:0] alu_A,
  output logic [data_width-1:0] alu_B,
  output logic [3:0]            alu_FuncCode,
  input  logic [data_width-1:0] alu_C,
  input  logic                  alu_OverflowFlag,
  output logic                  wb_valid,
  output logic [AddrW-1:0]      wb_rd,
  output logic [data_width-1:0] wb_data,
  output logic                  wb_overflow,
  output logic                  sticky_ovf,
  input  logic                  clr_ovf,
  input  logic                  ext_we,
  input  logic [AddrW-1:0]      ext_addr,
  input  logic [data_width-1:0] ext_data,
  input  logic [AddrW-1:0]      dbg_addr,
  output logic [data_width-1:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e                state_q, state_d;
  logic [data_width-1:0] regs_q [num_regs];
  logic [data_width-1:0] a_q, b_q, res_q;
  logic [3:0]            func_q;
  logic [AddrW-1:0]      rd_q;
  logic                  ovf_q;
  logic                  sticky_q;

  logic                  accept;
  logic [data_width-1:0] rs1_val, rs2_val;

  // r0 is hardwired to zero on every read path.
  always_comb begin
    rs1_val  = (in_rs1 == '0) ? '0 : regs_q[in_rs1];
    rs2_val  = (in_rs2 == '0) ? '0 : regs_q[in_rs2];
    dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
  end

  // Next-state logic and handshake/write-back outputs.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    wb_valid    = 1'b0;
    wb_rd       = '0;
    wb_data     = '0;
    wb_overflow = 1'b0;
    case (state_q)
      StIdle: begin
        in_ready = ~reset;
        if (in_valid && !reset) state_d = StExec;
      end
      StExec: state_d = StWb;
      StWb: begin
        wb_valid    = 1'b1;
        wb_rd       = rd_q;
        wb_data     = res_q;
        wb_overflow = ovf_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign accept       = in_valid && in_ready;
  assign alu_A        = a_q;
  assign alu_B        = b_q;
  assign alu_FuncCode = func_q;
  assign sticky_ovf   = sticky_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Operand and result latches; ALU inputs hold their value outside EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      func_q <= '0;
      rd_q   <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (accept) begin
        a_q    <= rs1_val;
        b_q    <= rs2_val;
        func_q <= in_func;
        rd_q   <= in_rd;
      end
      if (state_q == StExec) begin
        res_q <= alu_C;
        ovf_q <= alu_OverflowFlag;
      end
    end
  end

  // Register file: write-back in WB, external preload only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(num_regs); i++) regs_q[i] <= '0;
    end else if (state_q == StWb) begin
      if (rd_q != '0) regs_q[rd_q] <= res_q;
    end else if (state_q == StIdle && ext_we) begin
      if (ext_addr != '0) regs_q[ext_addr] <= ext_data;
    end
  end

  // Sticky overflow; a set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset)                          sticky_q <= 1'b0;
    else if (state_q == StWb && ovf_q)  sticky_q <= 1'b1;
    else if (clr_ovf)                   sticky_q <= 1'b0;
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed bench for alu_issue_wb; the ALU is a stub driven by the bench.
module tb_alu_issue_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_func;
  logic [1:0]  in_rd, in_rs1, in_rs2;
  logic [15:0] alu_A, alu_B;
  logic [3:0]  alu_FuncCode;
  logic [15:0] alu_C;
  logic        alu_OverflowFlag;
  logic        wb_valid;
  logic [1:0]  wb_rd;
  logic [15:0] wb_data;
  logic        wb_overflow;
  logic        sticky_ovf;
  logic        clr_ovf;
  logic        ext_we;
  logic [1:0]  ext_addr;
  logic [15:0] ext_data;
  logic [1:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_issue_wb dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_func          (in_func),
    .in_rd            (in_rd),
    .in_rs1           (in_rs1),
    .in_rs2           (in_rs2),
    .alu_A            (alu_A),
    .alu_B            (alu_B),
    .alu_FuncCode     (alu_FuncCode),
    .alu_C            (alu_C),
    .alu_OverflowFlag (alu_OverflowFlag),
    .wb_valid         (wb_valid),
    .wb_rd            (wb_rd),
    .wb_data          (wb_data),
    .wb_overflow      (wb_overflow),
    .sticky_ovf       (sticky_ovf),
    .clr_ovf          (clr_ovf),
    .ext_we           (ext_we),
    .ext_addr         (ext_addr),
    .ext_data         (ext_data),
    .dbg_addr         (dbg_addr),
    .dbg_data         (dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dbg(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    check(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  // Advance one full cycle; returns on the falling edge (sample/drive point).
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic present(input logic [3:0] f, input logic [1:0] rd, input logic [1:0] rs1,
                         input logic [1:0] rs2, input logic [15:0] c, input logic ovf);
    in_valid = 1'b1; in_func = f; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    alu_C = c; alu_OverflowFlag = ovf;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_func = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    alu_C = '0; alu_OverflowFlag = 1'b0; clr_ovf = 1'b0;
    ext_we = 1'b0; ext_addr = '0; ext_data = '0; dbg_addr = '0;

    // Reset
    step(); step();
    check("ready_in_reset", {31'h0, in_ready}, 32'h0);
    check("aluA_reset", {16'h0, alu_A}, 32'h0);
    reset = 1'b0;
    step();
    check("ready_after_reset", {31'h0, in_ready}, 32'h1);
    check("wbv_after_reset", {31'h0, wb_valid}, 32'h0);
    check("sticky_after_reset", {31'h0, sticky_ovf}, 32'h0);
    check_dbg("dbg_r0_reset", 2'd0, 16'h0);
    check_dbg("dbg_r1_reset", 2'd1, 16'h0);
    check_dbg("dbg_r2_reset", 2'd2, 16'h0);
    check_dbg("dbg_r3_reset", 2'd3, 16'h0);

    // Preload r1=5, r2=3
    ext_we = 1'b1; ext_addr = 2'd1; ext_data = 16'h0005;
    step();
    ext_addr = 2'd2; ext_data = 16'h0003;
    step();
    ext_we = 1'b0;
    check_dbg("preload_r1", 2'd1, 16'h0005);
    check_dbg("preload_r2", 2'd2, 16'h0003);

    // r3 = r1 op r2, stub returns 8
    present(4'h0, 2'd3, 2'd1, 2'd2, 16'h0008, 1'b0);
    step();  // EXEC
    in_valid = 1'b0;
    check("add_ready_exec", {31'h0, in_ready}, 32'h0);
    check("add_aluA", {16'h0, alu_A}, 32'h5);
    check("add_aluB", {16'h0, alu_B}, 32'h3);
    check("add_func", {28'h0, alu_FuncCode}, 32'h0);
    check("add_wbv_exec", {31'h0, wb_valid}, 32'h0);
    step();  // WB
    check("add_ready_wb", {31'h0, in_ready}, 32'h0);
    check("add_wbv", {31'h0, wb_valid}, 32'h1);
    check("add_wbrd", {30'h0, wb_rd}, 32'h3);
    check("add_wbdata", {16'h0, wb_data}, 32'h8);
    check("add_wbovf", {31'h0, wb_overflow}, 32'h0);
    step();  // IDLE
    check("add_wbv_done", {31'h0, wb_valid}, 32'h0);
    check("add_ready_back", {31'h0, in_ready}, 32'h1);
    check("add_aluA_hold", {16'h0, alu_A}, 32'h5);
    check_dbg("add_r3", 2'd3, 16'h0008);

    // Write to r0 is discarded but still pulses wb_valid
    present(4'hF, 2'd0, 2'd3, 2'd3, 16'hFFFF, 1'b0);
    step();
    in_valid = 1'b0;
    check("r0_aluA", {16'h0, alu_A}, 32'h8);
    check("r0_func", {28'h0, alu_FuncCode}, 32'hF);
    step();
    check("r0_wbv", {31'h0, wb_valid}, 32'h1);
    check("r0_wbdata", {16'h0, wb_data}, 32'hFFFF);
    step();
    check("r0_wbv_done", {31'h0, wb_valid}, 32'h0);
    check_dbg("r0_still_zero", 2'd0, 16'h0);

    // Overflowing op into r1, then clear
    present(4'h1, 2'd1, 2'd1, 2'd2, 16'h1234, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    check("ovf_wbovf", {31'h0, wb_overflow}, 32'h1);
    check("ovf_sticky_pre", {31'h0, sticky_ovf}, 32'h0);
    step();
    check("ovf_sticky_set", {31'h0, sticky_ovf}, 32'h1);
    check_dbg("ovf_r1", 2'd1, 16'h1234);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("ovf_sticky_clr", {31'h0, sticky_ovf}, 32'h0);

    // clr_ovf during WB of an overflowing op: set wins
    present(4'h2, 2'd3, 2'd1, 2'd1, 16'h0001, 1'b1);
    step();
    in_valid = 1'b0;
    step();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("set_beats_clr", {31'h0, sticky_ovf}, 32'h1);

    // Reset during EXEC aborts the op
    present(4'h3, 2'd2, 2'd1, 2'd1, 16'h7777, 1'b0);
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    check("abort_ready_rst", {31'h0, in_ready}, 32'h0);
    check("abort_wbv_rst", {31'h0, wb_valid}, 32'h0);
    reset = 1'b0;
    step();
    check("abort_wbv", {31'h0, wb_valid}, 32'h0);
    check("abort_ready", {31'h0, in_ready}, 32'h1);
    check("abort_aluA", {16'h0, alu_A}, 32'h0);
    check("abort_sticky", {31'h0, sticky_ovf}, 32'h0);
    check_dbg("abort_r2", 2'd2, 16'h0);
    step();
    check("abort_wbv_late", {31'h0, wb_valid}, 32'h0);

    // ext_we coincident with acceptance: operand sees old value
    ext_we = 1'b1; ext_addr = 2'd1; ext_data = 16'h0011;
    step();
    ext_addr = 2'd1; ext_data = 16'h00AA;
    present(4'h4, 2'd3, 2'd1, 2'd0, 16'h0055, 1'b0);
    step();  // EXEC
    in_valid = 1'b0;
    check("coin_aluA_old", {16'h0, alu_A}, 32'h0011);
    check("coin_aluB", {16'h0, alu_B}, 32'h0);
    check_dbg("coin_r1_new", 2'd1, 16'h00AA);
    ext_addr = 2'd2; ext_data = 16'hBEEF;  // during EXEC: ignored
    step();  // WB
    check_dbg("ext_exec_ignored", 2'd2, 16'h0);
    ext_data = 16'h1111;                   // during WB: ignored
    step();  // IDLE
    ext_we = 1'b0;
    check_dbg("ext_wb_ignored", 2'd2, 16'h0);
    check_dbg("coin_r3", 2'd3, 16'h0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
